// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer: FSM state encoding,
// counter width helper and default timing constants for a 50 MHz clock.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;   // 100 ms

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int cnt_width(input int unsigned max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs; RESET_VALUE
// sets the idle level both flops hold while reset is asserted.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchroniser, counter-based debounce FSM, registered
// level and press/release strobes. Define BUTTON_DEBOUNCER_AUTO_REPEAT_EN for auto-repeat.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 2**24) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_debouncer: repeat timing must be at least 1");
    end

    localparam int             CW     = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  THRESH = CW'(DEBOUNCE_CYCLES);

    deb_state_t    state, state_d;
    logic [CW-1:0] count, count_d;
    logic          btn_raw_sync;
    logic          btn_sync;
    logic          accept_press, accept_release, repeat_fire;
    logic          level_d, press_d, release_d;

    // Flops idle at the released pin level so leaving reset never looks like a press.
    sync_2ff #(
        .RESET_VALUE (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_raw_sync)
    );

    assign btn_sync = btn_raw_sync ^ ACTIVE_LOW;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            count         <= count_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // NOTE: defaults first in every combinational block so no path infers a latch.
    always_comb begin
        state_d = state;
        count_d = count;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PRESS_WAIT;
                    count_d = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count >= THRESH) begin
                    state_d = HELD;
                    count_d = '0;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = RELEASE_WAIT;
                    count_d = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = HELD;
                    count_d = '0;
                end else if (count >= THRESH) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign accept_press   = (state == PRESS_WAIT)   &&  btn_sync && (count >= THRESH);
    assign accept_release = (state == RELEASE_WAIT) && !btn_sync && (count >= THRESH);

    always_comb begin
        level_d   = btn_level;
        press_d   = accept_press | repeat_fire;
        release_d = accept_release;
        if (accept_press) begin
            level_d = 1'b1;
        end else if (accept_release) begin
            level_d = 1'b0;
        end
    end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    localparam int unsigned    RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int             RW    = cnt_width(RMAX);
    localparam logic [RW-1:0]  DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]  PER   = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rpt_cnt, rpt_cnt_d, rpt_cnt_inc;
    logic          rpt_first, rpt_first_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt_d;
            rpt_first <= rpt_first_d;
        end
    end

    assign rpt_cnt_inc = rpt_cnt + 1'b1;

    // Held in PRESS_WAIT so HELD is always entered with a fresh phase; frozen in RELEASE_WAIT.
    always_comb begin
        rpt_cnt_d   = rpt_cnt;
        rpt_first_d = rpt_first;
        repeat_fire = 1'b0;
        if (state_d == IDLE || state == PRESS_WAIT) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (state == HELD && btn_sync) begin
            if (rpt_cnt_inc == (rpt_first ? DELAY : PER)) begin
                repeat_fire = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_inc;
            end
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (DEBOUNCE_CYCLES = 8, ACTIVE_LOW = 1);
// the auto-repeat scenario runs when BUTTON_DEBOUNCER_AUTO_REPEAT_EN is defined.
module tb_button_debouncer;

    localparam int unsigned DEB = 8;
    // Input driven on a falling edge shows up at the output this many cycles later.
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_in = 1'b1;
    logic btn_level, press_pulse, release_pulse;

    int cycle = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        bit is_press;
        int cyc;
    } pulse_t;
    pulse_t exp_q[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic expect_pulse(input bit is_press, input int cyc);
        exp_q.push_back(pulse_t'{is_press, cyc});
    endtask

    // Advance to the next falling edge and score any strobe seen there.
    task automatic tick();
        pulse_t e;
        @(negedge clk);
        if (press_pulse || release_pulse) begin
            total++;
            if (press_pulse && release_pulse) begin
                bad++;
                $display("FAIL pulse_overlap: both strobes high at cycle %0d", cycle);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, none expected",
                         press_pulse, release_pulse, cycle);
            end else begin
                e = exp_q.pop_front();
                if (e.is_press !== press_pulse || e.cyc != cycle) begin
                    bad++;
                    $display("FAIL sb_pulse: got press=%b at cycle %0d, expected press=%b at cycle %0d",
                             press_pulse, cycle, e.is_press, e.cyc);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic tick_until(input int c);
        while (cycle < c) tick();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        btn_in = 1'b1;
        #23;
        total++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 000", {btn_level, press_pulse, release_pulse});
        end
        @(negedge clk);
        reset = 1'b1;
        ticks(100);
        total++;
        if (exp_q.size() != 0 || btn_level !== 1'b0) begin
            bad++;
            $display("FAIL reset_quiet: level=%b pending=%0d expected level 0 pending 0",
                     btn_level, exp_q.size());
        end
    endtask

    task automatic test_clean_press();
        int c;
        c = cycle;
        btn_in = 1'b0;
        expect_pulse(1'b1, c + LAT);
        tick_until(c + LAT - 1);
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_early: btn_level=%b expected 0", btn_level);
        end
        tick();
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL clean_level: btn_level=%b expected 1", btn_level);
        end
        tick_until(c + 20);
        btn_in = 1'b1;
        c = cycle;
        expect_pulse(1'b0, c + LAT);
        tick_until(c + LAT - 1);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL clean_release_early: btn_level=%b expected 1", btn_level);
        end
        tick();
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL clean_release_level: btn_level=%b expected 0", btn_level);
        end
        ticks(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL clean_drain: pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int c;
        for (int r = 0; r < 10; r++) begin
            btn_in = (r % 2 == 0) ? 1'b0 : 1'b1;
            ticks(3);
        end
        btn_in = 1'b0;
        c = cycle;
        expect_pulse(1'b1, c + LAT);
        tick_until(c + LAT);
        total++;
        if (btn_level !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_press: level=%b pending=%0d expected level 1 pending 0",
                     btn_level, exp_q.size());
        end
    endtask

    task automatic test_release();
        int c;
        btn_in = 1'b1;
        ticks(5);
        btn_in = 1'b0;
        ticks(2);
        btn_in = 1'b1;
        c = cycle;
        expect_pulse(1'b0, c + LAT);
        tick_until(c + LAT - 1);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL release_early: btn_level=%b expected 1", btn_level);
        end
        tick();
        total++;
        if (btn_level !== 1'b0) begin
            bad++;
            $display("FAIL release_level: btn_level=%b expected 0", btn_level);
        end
        ticks(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL release_drain: pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int c;
        btn_in = 1'b0;
        c = cycle;
        expect_pulse(1'b1, c + LAT);
        tick_until(c + LAT + 2);
        total++;
        if (btn_level !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_held: btn_level=%b expected 1", btn_level);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            bad++;
            $display("FAIL reset_held_async: got %b expected 000", {btn_level, press_pulse, release_pulse});
        end
        ticks(2);
        reset = 1'b1;
        c = cycle;
        tick_until(c + 7);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
            bad++;
            $display("FAIL reset_wait_async: got %b expected 000", {btn_level, press_pulse, release_pulse});
        end
        ticks(2);
        reset = 1'b1;
        c = cycle;
        expect_pulse(1'b1, c + LAT);
        tick_until(c + LAT);
        total++;
        if (btn_level !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_held_through: level=%b pending=%0d expected level 1 pending 0",
                     btn_level, exp_q.size());
        end
        btn_in = 1'b1;
        c = cycle;
        expect_pulse(1'b0, c + LAT);
        tick_until(c + LAT + 3);
        total++;
        if (btn_level !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_final_release: level=%b pending=%0d expected level 0 pending 0",
                     btn_level, exp_q.size());
        end
    endtask

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int p;
        int q;
        btn_in = 1'b0;
        p = cycle + LAT;
        expect_pulse(1'b1, p);
        expect_pulse(1'b1, p + 20);
        for (int k = 26; k <= 56; k += 6) expect_pulse(1'b1, p + k);
        tick_until(p + 57);
        btn_in = 1'b1;
        q = cycle;
        expect_pulse(1'b0, q + LAT);
        tick_until(q + LAT + 15);
        total++;
        if (btn_level !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL repeat_drain: level=%b pending=%0d expected level 0 pending 0",
                     btn_level, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_reset_mid();
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input conditioner for the mechanical push-buttons (KEY) that drive the board's command inputs, e.g. the convert strobe of the number-display path.
- Synchronises the raw button and filters contact bounce with a counter-based FSM.
- Outputs a clean level plus single-cycle press/release pulses, so downstream blocks need no edge detector or synchroniser of their own.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a change (10 ms at 50 MHz); legal range 1 to 2^24.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board KEYs); 0 = reads 1 when pressed.
- REPEAT_DELAY, 25000000, hold time before the first auto-repeat pulse (optional feature only).
- REPEAT_PERIOD, 5000000, spacing of later auto-repeat pulses (optional feature only).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw, asynchronous button pin.
- btn_level  output  1  debounced state, 1 = pressed.
- press_pulse  output  1  one-cycle strobe on an accepted press (and on each auto-repeat).
- release_pulse  output  1  one-cycle strobe on an accepted release.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-low; while reset = 0 all state is cleared immediately, independent of clk.
- Reset values: btn_level = 0, press_pulse = 0, release_pulse = 0, FSM = IDLE, counter = 0. Synchroniser flops reset to the released level (1 when ACTIVE_LOW = 1), so reset release never creates a pulse.
- Synchroniser: btn_in passes through 2 flops, then ACTIVE_LOW polarity is applied to give btn_sync (1 = pressed).
- FSM states: IDLE (released, stable), PRESS_WAIT, HELD (pressed, stable), RELEASE_WAIT.
- IDLE: btn_sync = 1 -> PRESS_WAIT, counter = 1.
- PRESS_WAIT, btn_sync = 0: -> IDLE, counter = 0; the bounce is discarded with no output.
- PRESS_WAIT, btn_sync = 1 and counter = DEBOUNCE_CYCLES: -> HELD; btn_level <= 1 and press_pulse <= 1 on the same edge.
- PRESS_WAIT, otherwise: counter increments.
- HELD: btn_sync = 0 -> RELEASE_WAIT, counter = 1.
- RELEASE_WAIT: symmetric to PRESS_WAIT. A return to pressed goes back to HELD silently. Reaching DEBOUNCE_CYCLES goes to IDLE with btn_level <= 0 and release_pulse <= 1.
- Latency: a clean edge first sampled at edge k produces its output change at edge k + 2 + DEBOUNCE_CYCLES.
- All outputs are registered. Pulses are exactly 1 cycle wide. press_pulse and release_pulse are never high in the same cycle.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes any output.
- DEBOUNCE_CYCLES = 1: the change is accepted on the first PRESS_WAIT/RELEASE_WAIT cycle.
- Counter width is clog2(DEBOUNCE_CYCLES + 1). The counter saturates at the threshold and never wraps.
- Reset asserted mid-debounce or while HELD: everything returns to the reset values with no release_pulse. After reset deasserts with the button still held, a full press debounce is required before press_pulse.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
- Defined: a separate repeat counter runs while in HELD and clears on entering HELD. press_pulse fires again REPEAT_DELAY cycles after the initial press_pulse, then every REPEAT_PERIOD cycles while still in HELD. Entering RELEASE_WAIT freezes the repeat counter; a return to HELD resumes it without resetting the phase. Exiting to IDLE or reset clears it.
- Not defined: no repeat counter is built. press_pulse fires once per accepted press, and REPEAT_DELAY/REPEAT_PERIOD are ignored.

Decomposition:
- Shared package: FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), the clog2-based width function, and default timing constants for a 50 MHz clock.
- One sub-module: sync_2ff, a generic two-flop synchroniser with a reset-value parameter, reusable for the switch inputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 8 and ACTIVE_LOW = 1.
- Clean press: btn_in 1 -> 0, held 20 cycles -> btn_level = 1 and press_pulse high for exactly 1 cycle, 10 cycles after the first sampling edge; release_pulse stays 0.
- Bounce: btn_in toggles with runs of 3 cycles for 30 cycles, then stays 0 -> exactly one press_pulse, 10 cycles after the final stable 0 is sampled; no release_pulse.
- Release: from HELD, btn_in = 1 for 5 cycles, 0 for 2, then 1 steady -> release_pulse exactly once; btn_level falls 10 cycles after the last rising edge.
- Reset mid-operation: reset = 0 asynchronously while in PRESS_WAIT with counter = 5 -> all outputs 0 immediately with no clk edge; hold button through reset release -> press_pulse 10 cycles after reset deasserts.
- Reset quiet: reset deasserts with btn_in = 1 -> no pulse for 100 cycles.
- Auto-repeat (macro defined; REPEAT_DELAY = 20, REPEAT_PERIOD = 6): hold 60 cycles -> press_pulse at cycles 0, 20, 26, 32, 38, 44, 50, 56 relative to the first pulse; none after release.
